alu_seq: RTL



---
 rtl/alu_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift/compare ops plus iterative
// radix-2 multiply, unsigned divide and remainder (WIDTH steps each).
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               illegal_q, illegal_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         iop_q, iop_d;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ill;
  logic               is_iter;
  logic               accept;
  logic [WIDTH-1:0]   mul_acc;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;

  assign shamt     = b[SHAMT_W-1:0];
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_iter   = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q == S_BUSY);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign illegal   = illegal_q;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_MUL, OP_DIVU, OP_REMU: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // x holds multiplicand (MUL) or dividend-becoming-quotient (DIV/REM);
  // y holds multiplier or divisor; acc holds partial product or remainder.
  // A zero divisor naturally yields quotient all-ones and remainder a.
  always_comb begin
    mul_acc = y_q[0] ? (acc_q + x_q) : acc_q;
    rem_sh  = {acc_q, x_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, y_q};
    rem_ge  = (rem_sh >= {1'b0, y_q});
    rem_nxt = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt = {x_q[WIDTH-2:0], rem_ge};
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    iop_d     = iop_q;
    case (state_q)
      S_BUSY: begin
        if (iop_q == OP_MUL) begin
          acc_d = mul_acc;
          x_d   = {x_q[WIDTH-2:0], 1'b0};
          y_d   = {1'b0, y_q[WIDTH-1:1]};
        end else begin
          acc_d = rem_nxt;
          x_d   = quo_nxt;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d   = S_HOLD;
          illegal_d = 1'b0;
          cnt_d     = '0;
          if (iop_q == OP_MUL)       result_d = mul_acc;
          else if (iop_q == OP_DIVU) result_d = quo_nxt;
          else                       result_d = rem_nxt;
        end
      end
      default: begin
        if (accept) begin
          if (is_iter) begin
            state_d = S_BUSY;
            x_d     = a;
            y_d     = b;
            acc_d   = '0;
            cnt_d   = '0;
            iop_d   = op;
          end else begin
            state_d   = S_HOLD;
            result_d  = alu_res;
            illegal_d = alu_ill;
          end
        end else if ((state_q == S_HOLD) && out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      iop_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      iop_q     <= iop_d;
    end
  end

endmodule
